// File: rtl/com_sched_pkg.sv
// Shared types and sizing helpers for the COM clock scheduler.
package com_sched_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    COM    = 2'd2,
    RESUME = 2'd3
  } state_t;

  localparam int DEF_CLK_FREQ  = 50_000_000;
  localparam int DEF_BAUD_RATE = 115200;

  // Board clocks per serial bit; integer division on purpose.
  function automatic int pulse_width(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/com_clock_scheduler_if.sv
// Request/enable bundle between CPU core, UART side and the scheduler.
// com_timeout exists only when COM_TIMEOUT_EN is defined.
interface com_clock_scheduler_if;
  logic com_req;
  logic com_done;
  logic cpu_en;
  logic fetch_stall;
  logic baud_tick;
  logic com_active;
`ifdef COM_TIMEOUT_EN
  logic com_timeout;
`endif

  modport master (
    output com_req,
    output com_done,
    input  cpu_en,
    input  fetch_stall,
    input  baud_tick,
`ifdef COM_TIMEOUT_EN
    input  com_timeout,
`endif
    input  com_active
  );

  modport slave (
    input  com_req,
    input  com_done,
    output cpu_en,
    output fetch_stall,
    output baud_tick,
`ifdef COM_TIMEOUT_EN
    output com_timeout,
`endif
    output com_active
  );
endinterface

// File: rtl/baud_tick_gen.sv
// Baud-period counter: free-runs while run is high, one registered tick per
// PULSE_WIDTH cycles; dropping run discards any partial period.
module baud_tick_gen
  import com_sched_pkg::*;
#(
  parameter int PULSE_WIDTH = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam int CW = cnt_width(PULSE_WIDTH - 1);

  logic [CW-1:0] cnt;

  // Count 0..PULSE_WIDTH-1; tick is high in the cycle after the terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (!run) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == CW'(PULSE_WIDTH - 1));
      cnt  <= (cnt == CW'(PULSE_WIDTH - 1)) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/com_clock_scheduler.sv
// Switches the CPU between full-rate execution and baud-rate COM stepping
// using clock enables only. Optional watchdog: define COM_TIMEOUT_EN.
//
// state  | meaning
// RUN    | full rate, waiting for a com_req rising edge
// DRAIN  | fetch stalled while in-flight instructions retire
// COM    | CPU advances only on baud ticks until com_done
// RESUME | one cycle with CPU held and fetch stalled, then RUN
module com_clock_scheduler
  import com_sched_pkg::*;
#(
  parameter int CLK_FREQ     = DEF_CLK_FREQ,
  parameter int BAUD_RATE    = DEF_BAUD_RATE,
  parameter int DRAIN_CYCLES = 5
`ifdef COM_TIMEOUT_EN
  , parameter int TIMEOUT_TICKS = 4096
`endif
) (
  input logic                    clk,
  input logic                    rst_n,
  com_clock_scheduler_if.slave   bus
);

  localparam int PULSE_WIDTH = pulse_width(CLK_FREQ, BAUD_RATE);
  localparam int DW          = cnt_width(DRAIN_CYCLES);

  state_t        state;
  logic [DW-1:0] drain_cnt;
  logic          com_req_q;
  logic          req_edge;
  logic          in_com;
  logic          tick;
  logic          timeout_hit;

  assign req_edge = bus.com_req & ~com_req_q;
  assign in_com   = (state == COM);

  baud_tick_gen #(.PULSE_WIDTH(PULSE_WIDTH)) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (in_com),
    .tick  (tick)
  );

`ifdef COM_TIMEOUT_EN
  localparam int TW = cnt_width(TIMEOUT_TICKS);

  logic [TW-1:0] tick_cnt;
  logic          com_timeout_q;

  // The tick that brings the count to TIMEOUT_TICKS is the forcing one.
  assign timeout_hit = in_com & tick & (tick_cnt == TW'(TIMEOUT_TICKS - 1));

  // Watchdog tick count per COM visit; timeout pulse lands in the RESUME cycle
  // unless com_done arrived alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt      <= '0;
      com_timeout_q <= 1'b0;
    end else begin
      com_timeout_q <= timeout_hit & ~bus.com_done;
      if (!in_com)
        tick_cnt <= '0;
      else if (tick)
        tick_cnt <= tick_cnt + TW'(1);
    end
  end

  assign bus.com_timeout = com_timeout_q;
`else
  assign timeout_hit = 1'b0;
`endif

  // Sequencing FSM with request edge detection and drain timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      drain_cnt <= '0;
      com_req_q <= 1'b0;
    end else begin
      com_req_q <= bus.com_req;
      case (state)
        RUN: begin
          drain_cnt <= '0;
          if (req_edge)
            state <= (DRAIN_CYCLES == 0) ? COM : DRAIN;
        end
        DRAIN: begin
          if (drain_cnt == DW'(DRAIN_CYCLES - 1))
            state <= COM;
          else
            drain_cnt <= drain_cnt + DW'(1);
        end
        COM: begin
          if (bus.com_done || timeout_hit)
            state <= RESUME;
        end
        RESUME:  state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  // A tick registered on the COM exit edge must not leak into RESUME.
  assign bus.baud_tick   = tick & in_com;
  assign bus.cpu_en      = (state == RUN) | (state == DRAIN) | (tick & in_com);
  assign bus.fetch_stall = (state == DRAIN) | (state == RESUME);
  assign bus.com_active  = in_com;

endmodule

// File: tb/tb_com_clock_scheduler.sv
// Bench for com_clock_scheduler: PULSE_WIDTH=10, DRAIN_CYCLES=3 (plus a
// DRAIN_CYCLES=0 instance), TIMEOUT_TICKS=4 when COM_TIMEOUT_EN is defined.
module tb_com_clock_scheduler;

  // Expected vector layout: {cpu_en, fetch_stall, baud_tick, com_active, com_timeout}
  localparam logic [4:0] RUNV  = 5'b10000;
  localparam logic [4:0] DRV   = 5'b11000;
  localparam logic [4:0] COMV  = 5'b00010;
  localparam logic [4:0] TICKV = 5'b10110;
  localparam logic [4:0] RESV  = 5'b01000;
  localparam logic [4:0] RESTO = 5'b01001;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   passed = 0;
  logic [4:0] sb[$];
  logic [4:0] obs_m;
  logic [4:0] obs_z;

  com_clock_scheduler_if bus ();
  com_clock_scheduler_if bus0 ();

  com_clock_scheduler #(
    .CLK_FREQ     (1000),
    .BAUD_RATE    (100),
    .DRAIN_CYCLES (3)
`ifdef COM_TIMEOUT_EN
    , .TIMEOUT_TICKS (4)
`endif
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  com_clock_scheduler #(
    .CLK_FREQ     (1000),
    .BAUD_RATE    (100),
    .DRAIN_CYCLES (0)
`ifdef COM_TIMEOUT_EN
    , .TIMEOUT_TICKS (4)
`endif
  ) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

`ifdef COM_TIMEOUT_EN
  assign obs_m = {bus.cpu_en, bus.fetch_stall, bus.baud_tick, bus.com_active, bus.com_timeout};
  assign obs_z = {bus0.cpu_en, bus0.fetch_stall, bus0.baud_tick, bus0.com_active, bus0.com_timeout};
`else
  assign obs_m = {bus.cpu_en, bus.fetch_stall, bus.baud_tick, bus.com_active, 1'b0};
  assign obs_z = {bus0.cpu_en, bus0.fetch_stall, bus0.baud_tick, bus0.com_active, 1'b0};
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected vector for a DRAIN(3) entry whose request edge is driven at k_req.
  function automatic logic [4:0] seq_exp(int k, int k_req, int k_done);
    int c;
    c = k - k_req - 3;
    if (k < k_req) return RUNV;
    if (c < 0) return DRV;
    if (k < k_done) return (c != 0 && c % 10 == 0) ? TICKV : COMV;
    if (k == k_done) return RESV;
    return RUNV;
  endfunction

  task automatic test_reset();
    logic [4:0] e;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs_m !== RUNV) $display("FAIL reset_async got=%b exp=%b", obs_m, RUNV);
    else passed++;
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sb.push_back(RUNV);
      step();
      e = sb.pop_front();
      checks++;
      if (obs_m !== e || obs_z !== e) $display("FAIL reset_idle k=%0d got=%b/%b exp=%b", k, obs_m, obs_z, e);
      else passed++;
    end
  endtask

  // Request held high throughout; com_done one cycle after the third tick.
  task automatic test_basic();
    logic [4:0] e;
    for (int k = 0; k < 46; k++) begin
      bus.com_req  = 1'b1;
      bus.com_done = (k == 35);
      sb.push_back(seq_exp(k, 0, 35));
      step();
      e = sb.pop_front();
      checks++;
      if (obs_m !== e) $display("FAIL basic k=%0d got=%b exp=%b", k, obs_m, e);
      else passed++;
    end
  endtask

  // com_done high during the first tick cycle: tick delivered, then RESUME.
  task automatic test_coincident();
    logic [4:0] e;
    for (int k = 0; k < 26; k++) begin
      bus.com_req  = (k >= 1);
      bus.com_done = (k == 15);
      sb.push_back(seq_exp(k, 1, 15));
      step();
      e = sb.pop_front();
      checks++;
      if (obs_m !== e) $display("FAIL coincident k=%0d got=%b exp=%b", k, obs_m, e);
      else passed++;
    end
  endtask

  // com_done in RUN/DRAIN ignored, req edge in COM dropped, exit on the
  // terminal-count cycle shows no tick in RESUME.
  task automatic test_ignored();
    logic [4:0] e;
    for (int k = 0; k < 23; k++) begin
      bus.com_req  = (k == 2 || k == 3 || k >= 6);
      bus.com_done = (k == 0 || k == 3 || k == 15);
      sb.push_back(seq_exp(k, 2, 15));
      step();
      e = sb.pop_front();
      checks++;
      if (obs_m !== e) $display("FAIL ignored k=%0d got=%b exp=%b", k, obs_m, e);
      else passed++;
    end
  endtask

  task automatic test_reset_in_com();
    logic [4:0] e;
    for (int k = 0; k < 11; k++) begin
      bus.com_req  = (k >= 1);
      bus.com_done = 1'b0;
      sb.push_back(seq_exp(k, 1, 99));
      step();
      e = sb.pop_front();
      checks++;
      if (obs_m !== e) $display("FAIL rst_com_pre k=%0d got=%b exp=%b", k, obs_m, e);
      else passed++;
    end
    rst_n = 1'b0;
    bus.com_req = 1'b0;
    #1;
    checks++;
    if (obs_m !== RUNV) $display("FAIL rst_com_async got=%b exp=%b", obs_m, RUNV);
    else passed++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 17; k++) begin
      bus.com_req  = (k >= 1);
      bus.com_done = (k == 15);
      sb.push_back(seq_exp(k, 1, 15));
      step();
      e = sb.pop_front();
      checks++;
      if (obs_m !== e) $display("FAIL rst_com_post k=%0d got=%b exp=%b", k, obs_m, e);
      else passed++;
    end
  endtask

  task automatic test_zero_drain();
    logic [4:0] e;
    for (int k = 0; k < 16; k++) begin
      bus0.com_req  = (k >= 1);
      bus0.com_done = (k == 12);
      if (k == 0)       e = RUNV;
      else if (k < 11)  e = COMV;
      else if (k == 11) e = TICKV;
      else if (k == 12) e = RESV;
      else              e = RUNV;
      sb.push_back(e);
      step();
      e = sb.pop_front();
      checks++;
      if (obs_z !== e) $display("FAIL zero_drain k=%0d got=%b exp=%b", k, obs_z, e);
      else passed++;
    end
  endtask

`ifdef COM_TIMEOUT_EN
  // v=0: no com_done, watchdog fires; v=1: com_done on the 4th tick cycle.
  task automatic test_watchdog();
    logic [4:0] e;
    for (int v = 0; v < 2; v++) begin
      for (int k = 0; k < 48; k++) begin
        bus.com_req  = (k >= 1);
        bus.com_done = (v == 1 && k == 45);
        e = seq_exp(k, 1, 45);
        if (k == 45 && v == 0) e = RESTO;
        sb.push_back(e);
        step();
        e = sb.pop_front();
        checks++;
        if (obs_m !== e) $display("FAIL watchdog v=%0d k=%0d got=%b exp=%b", v, k, obs_m, e);
        else passed++;
      end
    end
  endtask
`endif

  initial begin
    rst_n         = 1'b1;
    bus.com_req   = 1'b0;
    bus.com_done  = 1'b0;
    bus0.com_req  = 1'b0;
    bus0.com_done = 1'b0;
    test_reset();
    test_basic();
    test_coincident();
    test_ignored();
    test_reset_in_com();
    test_zero_drain();
`ifdef COM_TIMEOUT_EN
    test_watchdog();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
